// File: rtl/sprite_compositor.sv
`default_nettype none
// ============================================================================
// sprite_compositor : double-buffered sprite/bullet compositor, 12-bit RGB out
// Rev 1.0
// ============================================================================
module sprite_compositor #(
   parameter int          NUM_SPRITES  = 2,
   parameter int          MAX_BULLETS  = 64,
   parameter int          SPRITE_SIZE  = 64,
   parameter int          BULLET_SIZE  = 12,
   parameter int          ROM_LAT      = 1,
   parameter logic [11:0] BULLET_COLOR = 12'hF00,
   parameter logic [11:0] KEY_COLOR    = 12'hF0F,
   localparam int         NUM_OBJ      = NUM_SPRITES + MAX_BULLETS,
   localparam int         AW           = $clog2(NUM_OBJ),
   localparam int         SAW          = $clog2(SPRITE_SIZE * SPRITE_SIZE)
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic [9:0]                 pix_x,
   input  logic [8:0]                 pix_y,
   input  logic                       pix_active,
   input  logic                       pix_hsync,
   input  logic                       pix_vsync,
   input  logic                       frame_end,
   input  logic                       display_en,
   input  logic                       attr_wr_en,
   input  logic [AW-1:0]              attr_wr_addr,
   input  logic [31:0]                attr_wr_data,
   output logic [NUM_SPRITES*SAW-1:0] spr_addr,
   input  logic [NUM_SPRITES*12-1:0]  spr_color,
   input  logic [11:0]                bg_color,
   output logic [11:0]                vga_rgb,
   output logic                       hsync_o,
   output logic                       vsync_o,
   output logic                       commit,
   output logic [15:0]                frame_cnt
);

   localparam int DW = NUM_SPRITES + 4;
   localparam logic [DW-1:0] DLY_RST = {{(DW-2){1'b0}}, 2'b11};

   logic [9:0] sh_x  [NUM_OBJ];
   logic [8:0] sh_y  [NUM_OBJ];
   logic       sh_en [NUM_OBJ];
   logic [9:0] lv_x  [NUM_OBJ];
   logic [8:0] lv_y  [NUM_OBJ];
   logic       lv_en [NUM_OBJ];

   logic [9:0]         wr_x;
   logic [8:0]         wr_y;
   logic               wr_enable;
   logic [NUM_OBJ-1:0] wr_sel;
   logic               unused_attr_bits;

   assign wr_x             = attr_wr_data[31:22];
   assign wr_y             = attr_wr_data[21:13];
   assign wr_enable        = attr_wr_data[2];
   assign unused_attr_bits = ^{attr_wr_data[12:3], attr_wr_data[1:0]};

   // Out-of-range addresses match no entry and are dropped.
   always_comb begin
      wr_sel = '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
         wr_sel[i] = attr_wr_en && (attr_wr_addr == AW'(i));
      end
   end

   // A write landing in the frame_end cycle is forwarded into the live copy.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_OBJ; i++) begin
            sh_x[i]  <= '0;
            sh_y[i]  <= '0;
            sh_en[i] <= 1'b0;
            lv_x[i]  <= '0;
            lv_y[i]  <= '0;
            lv_en[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < NUM_OBJ; i++) begin
            if (wr_sel[i]) begin
               sh_x[i]  <= wr_x;
               sh_y[i]  <= wr_y;
               sh_en[i] <= wr_enable;
            end
            if (frame_end) begin
               lv_x[i]  <= wr_sel[i] ? wr_x      : sh_x[i];
               lv_y[i]  <= wr_sel[i] ? wr_y      : sh_y[i];
               lv_en[i] <= wr_sel[i] ? wr_enable : sh_en[i];
            end
         end
      end
   end

   // Widened compares so objects near the right/bottom edge never wrap.
   function automatic logic in_box(input logic [9:0] px, input logic [8:0] py,
                                   input logic [9:0] ox, input logic [8:0] oy,
                                   input logic [10:0] size);
      logic [10:0] xp, x0;
      logic [9:0]  yp, y0;
      xp = {1'b0, px};
      x0 = {1'b0, ox};
      yp = {1'b0, py};
      y0 = {1'b0, oy};
      return (xp >= x0) && (xp < x0 + size) && (yp >= y0) && (yp < y0 + size[9:0]);
   endfunction

   logic [NUM_SPRITES-1:0] spr_hit;
   logic [MAX_BULLETS-1:0] bul_hit;

   generate
      for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
         assign spr_hit[i] = lv_en[i] &&
                             in_box(pix_x, pix_y, lv_x[i], lv_y[i], 11'(SPRITE_SIZE));
         assign spr_addr[i*SAW +: SAW] = (SAW'(pix_x) - SAW'(lv_x[i])) +
                                         SAW'(SPRITE_SIZE) * (SAW'(pix_y) - SAW'(lv_y[i]));
      end
      for (genvar j = 0; j < MAX_BULLETS; j++) begin : g_bul
         assign bul_hit[j] = lv_en[NUM_SPRITES+j] &&
                             in_box(pix_x, pix_y, lv_x[NUM_SPRITES+j], lv_y[NUM_SPRITES+j],
                                    11'(BULLET_SIZE));
      end
   endgenerate

   logic [DW-1:0] stage_in;
   logic [DW-1:0] stage_out;

   assign stage_in = {spr_hit, |bul_hit, pix_active, pix_hsync, pix_vsync};

   // Align per-pixel flags with the ROM data returning ROM_LAT cycles later.
   generate
      if (ROM_LAT > 0) begin : g_dly
         logic [DW-1:0] dly [ROM_LAT];
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               for (int k = 0; k < ROM_LAT; k++) begin
                  dly[k] <= DLY_RST;
               end
            end else begin
               dly[0] <= stage_in;
               for (int k = 1; k < ROM_LAT; k++) begin
                  dly[k] <= dly[k-1];
               end
            end
         end
         assign stage_out = dly[ROM_LAT-1];
      end else begin : g_nodly
         assign stage_out = stage_in;
      end
   endgenerate

   logic [NUM_SPRITES-1:0] d_spr;
   logic                   d_bul;
   logic                   d_act;
   logic                   d_hs;
   logic                   d_vs;
   logic [11:0]            rgb_next;

   assign d_spr = stage_out[DW-1:4];
   assign d_bul = stage_out[3];
   assign d_act = stage_out[2];
   assign d_hs  = stage_out[1];
   assign d_vs  = stage_out[0];

   // Scan from the top layer down so the lowest-index opaque sprite wins.
   always_comb begin
      rgb_next = bg_color;
      if (d_bul) begin
         rgb_next = BULLET_COLOR;
      end
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (d_spr[i] && (spr_color[i*12 +: 12] != KEY_COLOR)) begin
            rgb_next = spr_color[i*12 +: 12];
         end
      end
      if (!d_act || !display_en) begin
         rgb_next = 12'h000;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vga_rgb   <= 12'h000;
         hsync_o   <= 1'b1;
         vsync_o   <= 1'b1;
         commit    <= 1'b0;
         frame_cnt <= 16'h0000;
      end else begin
         vga_rgb <= rgb_next;
         hsync_o <= d_hs;
         vsync_o <= d_vs;
         commit  <= frame_end;
         if (frame_end) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sprite_compositor.sv
`default_nettype none
// tb_sprite_compositor : directed scoreboard bench for sprite_compositor (default parameters).
module tb_sprite_compositor;

   localparam int NS  = 2;
   localparam int NB  = 64;
   localparam int LAT = 2;
   localparam int AW  = 7;
   localparam int SAW = 12;
   localparam logic [11:0] KEY = 12'hF0F;

   logic              clk = 1'b0;
   logic              resetn = 1'b1;
   logic [9:0]        pix_x = '0;
   logic [8:0]        pix_y = '0;
   logic              pix_active = 1'b0;
   logic              pix_hsync = 1'b1;
   logic              pix_vsync = 1'b1;
   logic              frame_end = 1'b0;
   logic              display_en = 1'b1;
   logic              attr_wr_en = 1'b0;
   logic [AW-1:0]     attr_wr_addr = '0;
   logic [31:0]       attr_wr_data = '0;
   logic [NS*SAW-1:0] spr_addr;
   logic [NS*12-1:0]  spr_color = '0;
   logic [11:0]       bg_color = '0;
   logic [11:0]       vga_rgb;
   logic              hsync_o;
   logic              vsync_o;
   logic              commit;
   logic [15:0]       frame_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          chk;
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
      string       tag;
   } exp_t;
   exp_t q[$];

   logic        ovr_en  [NS];
   logic [11:0] ovr_val [NS];
   logic          nx_fe   = 1'b0;
   logic          nx_wr   = 1'b0;
   logic [AW-1:0] nx_addr = '0;
   logic [31:0]   nx_data = '0;

   always #5 clk = ~clk;

   sprite_compositor dut (
      .clk          (clk),
      .resetn       (resetn),
      .pix_x        (pix_x),
      .pix_y        (pix_y),
      .pix_active   (pix_active),
      .pix_hsync    (pix_hsync),
      .pix_vsync    (pix_vsync),
      .frame_end    (frame_end),
      .display_en   (display_en),
      .attr_wr_en   (attr_wr_en),
      .attr_wr_addr (attr_wr_addr),
      .attr_wr_data (attr_wr_data),
      .spr_addr     (spr_addr),
      .spr_color    (spr_color),
      .bg_color     (bg_color),
      .vga_rgb      (vga_rgb),
      .hsync_o      (hsync_o),
      .vsync_o      (vsync_o),
      .commit       (commit),
      .frame_cnt    (frame_cnt)
   );

   function automatic logic [11:0] bg_of(input logic [9:0] x, input logic [8:0] y);
      return {y[3:0], x[7:0]};
   endfunction

   function automatic logic [31:0] attr(input logic [9:0] x, input logic [8:0] y, input logic en);
      return {x, y, 10'd0, en, 2'b00};
   endfunction

   // ROM models with one cycle of read latency.
   always @(posedge clk) begin
      for (int i = 0; i < NS; i++) begin
         spr_color[i*12 +: 12] <= ovr_en[i] ? ovr_val[i]
                                            : spr_addr[i*SAW +: SAW] + 12'h111 * 12'(i + 1);
      end
      bg_color <= bg_of(pix_x, pix_y);
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [9:0] x, input logic [8:0] y, input logic act,
                       input logic hs, input logic vs, input bit chk,
                       input logic [11:0] exp, input string tag);
      exp_t e;
      @(negedge clk);
      if (q.size() == LAT) begin
         e = q.pop_front();
         if (e.chk) begin
            checks++;
            assert ({vga_rgb, hsync_o, vsync_o} === {e.rgb, e.hs, e.vs}) else begin
               errors++;
               $error("FAIL %s observed rgb=%h hs=%b vs=%b expected rgb=%h hs=%b vs=%b",
                      e.tag, vga_rgb, hsync_o, vsync_o, e.rgb, e.hs, e.vs);
            end
         end
      end
      pix_x        = x;
      pix_y        = y;
      pix_active   = act;
      pix_hsync    = hs;
      pix_vsync    = vs;
      frame_end    = nx_fe;
      attr_wr_en   = nx_wr;
      attr_wr_addr = nx_addr;
      attr_wr_data = nx_data;
      nx_fe = 1'b0;
      nx_wr = 1'b0;
      e.chk = chk;
      e.rgb = exp;
      e.hs  = hs;
      e.vs  = vs;
      e.tag = tag;
      q.push_back(e);
   endtask

   task automatic px(input logic [9:0] x, input logic [8:0] y, input logic [11:0] exp,
                     input string tag);
      step(x, y, 1'b1, 1'b1, 1'b1, 1'b1, exp, tag);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, "idle");
   endtask

   task automatic wr_commit(input logic [AW-1:0] a, input logic [31:0] d);
      nx_wr = 1'b1; nx_addr = a; nx_data = d;
      idle(1);
      nx_fe = 1'b1;
      idle(3);
   endtask

   initial begin
      for (int i = 0; i < NS; i++) begin
         ovr_en[i]  = 1'b0;
         ovr_val[i] = 12'h000;
      end
      #2 resetn = 1'b0;
      #1;
      check("rst_rgb",    {4'h0, vga_rgb},         16'h0000);
      check("rst_hsync",  {15'h0, hsync_o},        16'h0001);
      check("rst_vsync",  {15'h0, vsync_o},        16'h0001);
      check("rst_commit", {15'h0, commit},         16'h0000);
      check("rst_fcnt",   frame_cnt,               16'h0000);
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      idle(2);

      // Shadow write alone must not reach the display.
      nx_wr = 1'b1; nx_addr = 7'd0; nx_data = attr(10'd100, 9'd50, 1'b1);
      px(10'd100, 9'd50, bg_of(10'd100, 9'd50), "pre_commit");
      idle(1);
      nx_fe = 1'b1;
      idle(2);
      check("commit_pulse", {15'h0, commit}, 16'h0001);
      check("fcnt_1",       frame_cnt,       16'h0001);
      idle(1);
      check("commit_low",   {15'h0, commit}, 16'h0000);

      px(10'd100, 9'd50,  12'h111,                  "spr0_origin");
      px(10'd163, 9'd113, 12'h110,                  "spr0_corner");
      px(10'd164, 9'd50,  bg_of(10'd164, 9'd50),    "spr0_right_out");
      px(10'd100, 9'd114, bg_of(10'd100, 9'd114),   "spr0_bottom_out");
      step(10'd100, 9'd50, 1'b1, 1'b0, 1'b1, 1'b1, 12'h111, "hsync_dly");
      step(10'd100, 9'd50, 1'b1, 1'b1, 1'b0, 1'b1, 12'h111, "vsync_dly");

      // Layer priority and key transparency.
      wr_commit(7'd1, attr(10'd110, 9'd55, 1'b1));
      ovr_en[0] = 1'b1; ovr_val[0] = KEY;
      ovr_en[1] = 1'b1; ovr_val[1] = 12'h0F0;
      px(10'd120, 9'd60, 12'h0F0,                "key_fall");
      px(10'd105, 9'd52, bg_of(10'd105, 9'd52),  "key_to_bg");
      idle(2);
      ovr_val[0] = 12'h00F;
      px(10'd120, 9'd60, 12'h00F,                "spr_prio");
      idle(2);
      ovr_en[0] = 1'b0;
      ovr_en[1] = 1'b0;

      // Bullet 5 square edges.
      wr_commit(7'(NS + 5), attr(10'd200, 9'd100, 1'b1));
      px(10'd200, 9'd100, 12'hF00,                "bullet_origin");
      px(10'd211, 9'd111, 12'hF00,                "bullet_corner");
      px(10'd212, 9'd100, bg_of(10'd212, 9'd100), "bullet_right_out");
      px(10'd200, 9'd112, bg_of(10'd200, 9'd112), "bullet_bottom_out");

      // Sprite near the right edge: no wrap to column 0.
      wr_commit(7'd0, attr(10'd600, 9'd50, 1'b1));
      px(10'd639, 9'd50, 12'h138, "edge_hit");
      #1 check("edge_addr", {4'h0, spr_addr[SAW-1:0]}, 16'd39);
      px(10'd0, 9'd50, bg_of(10'd0, 9'd50), "edge_nowrap");

      idle(2);
      display_en = 1'b0;
      px(10'd639, 9'd50, 12'h000, "display_off");
      idle(2);
      display_en = 1'b1;
      step(10'd639, 9'd50, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, "inactive");

      // Disable bullet 5 in the frame_end cycle itself.
      nx_wr = 1'b1; nx_addr = 7'(NS + 5); nx_data = attr(10'd200, 9'd100, 1'b0);
      nx_fe = 1'b1;
      idle(2);
      px(10'd205, 9'd105, bg_of(10'd205, 9'd105), "coincident_commit");
      check("fcnt_5", frame_cnt, 16'h0005);

      // Asynchronous reset mid-frame.
      repeat (3) step(10'd639, 9'd50, 1'b1, 1'b0, 1'b0, 1'b1, 12'h138, "pre_reset");
      #2 resetn = 1'b0;
      #1;
      check("mid_rst_rgb",   {4'h0, vga_rgb},  16'h0000);
      check("mid_rst_hsync", {15'h0, hsync_o}, 16'h0001);
      check("mid_rst_vsync", {15'h0, vsync_o}, 16'h0001);
      check("mid_rst_fcnt",  frame_cnt,        16'h0000);
      q.delete();
      @(negedge clk);
      resetn = 1'b1;
      px(10'd100, 9'd50, bg_of(10'd100, 9'd50), "post_rst_bank0");
      px(10'd639, 9'd50, bg_of(10'd639, 9'd50), "post_rst_bank1");
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
